// File: rtl/dm_byteen_ram.sv
// Data memory for the MIPS core: byte-lane writes, pipelined reads with a
// fixed latency, an address window and a hardware zero-clear after reset.
// Every in-window write also pushes {pc, aligned address, merged word} into
// a small first-word-fall-through FIFO for an external trace sink.
module dm_byteen_ram #(
  parameter int          ADDR_W    = 12,
  parameter int          LANES     = 4,
  parameter int          READ_LAT  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          LOG_DEPTH = 8,
  localparam int         DATA_W    = 8 * LANES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [LANES-1:0]  req_byteen,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [31:0]       req_pc,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [31:0]       log_pc,
  output logic [31:0]       log_addr,
  output logic [DATA_W-1:0] log_data,
  output logic              clearing
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LSB_W = $clog2(LANES);
  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [32:0] WIN_BYTES = 33'(LANES) << ADDR_W;
  localparam logic [31:0] ALIGN_MASK = ~32'(LANES - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  // Replace the enabled byte lanes of the old word with the new data.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [LANES-1:0]  be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int l = 0; l < LANES; l++) begin
      if (be[l]) res[l*8 +: 8] = new_w[l*8 +: 8];
    end
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clear_ptr_q, clear_ptr_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [31:0]         off;
  logic                in_range;
  logic [ADDR_W-1:0]   idx;
  logic                accept;
  logic                wr_en;

  // Read pipeline: element 0 is the first registered stage.
  logic                vld_pn   [READ_LAT];
  logic                err_pn   [READ_LAT];
  logic [DATA_W-1:0]   rdata_pn [READ_LAT];

  // Write accepted last cycle, waiting for its merged word to be logged.
  logic                pend_q;
  logic [31:0]         pend_pc_q;
  logic [31:0]         pend_addr_q;
  logic [DATA_W-1:0]   pend_wdata_q;
  logic [LANES-1:0]    pend_be_q;

  logic [31:0]         fifo_pc   [LOG_DEPTH];
  logic [31:0]         fifo_addr [LOG_DEPTH];
  logic [DATA_W-1:0]   fifo_data [LOG_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                push, pop;
  logic [CNT_W:0]      occupancy;

  // Window decode of the incoming byte address.
  always_comb begin
    off      = req_addr - BASE_ADDR;
    in_range = (req_addr >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES);
    idx      = off[LSB_W +: ADDR_W];
    accept   = req_valid & req_ready;
    wr_en    = accept & in_range & (|req_byteen);
  end

  // FSM state register and clear pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  // FSM next state: sweep every word once, then run.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    if (state_q == ST_CLEAR) begin
      clear_ptr_d = clear_ptr_q + 1'b1;
      if (&clear_ptr_q) state_d = ST_RUN;
    end
  end

  // FSM outputs: accept only while the log can absorb every write in flight.
  always_comb begin
    occupancy = {1'b0, cnt_q} + (CNT_W+1)'(pend_q);
    clearing  = (state_q == ST_CLEAR);
    req_ready = (state_q == ST_RUN) && (occupancy < (CNT_W+1)'(LOG_DEPTH));
  end

  // Memory array: clear or lane write, read-first stage 1 and data shift.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clear_ptr_q] <= '0;
    end else if (wr_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (req_byteen[l]) mem[idx][l*8 +: 8] <= req_wdata[l*8 +: 8];
      end
    end
    // --- stage p1: old word of the addressed location ---
    rdata_pn[0] <= mem[idx];
    // --- stages p2..: pure delay up to READ_LAT ---
    for (int k = 1; k < READ_LAT; k++) rdata_pn[k] <= rdata_pn[k-1];
  end

  // Response valid/error pipeline; cleared on reset so in-flight reads vanish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < READ_LAT; k++) begin
        vld_pn[k] <= 1'b0;
        err_pn[k] <= 1'b0;
      end
    end else begin
      vld_pn[0] <= accept;
      err_pn[0] <= accept & ~in_range;
      for (int k = 1; k < READ_LAT; k++) begin
        vld_pn[k] <= vld_pn[k-1];
        err_pn[k] <= err_pn[k-1];
      end
    end
  end

  // Response outputs; data is forced to zero for errors and idle cycles.
  always_comb begin
    rsp_valid = vld_pn[READ_LAT-1];
    rsp_err   = err_pn[READ_LAT-1];
    rsp_rdata = (vld_pn[READ_LAT-1] && !err_pn[READ_LAT-1]) ? rdata_pn[READ_LAT-1] : '0;
  end

  // Pending-log flag: one cycle between accepting a write and logging it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= 1'b0;
    else        pend_q <= wr_en;
  end

  // Pending-log payload captured with the accepted write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pend_pc_q    <= req_pc;
      pend_addr_q  <= req_addr & ALIGN_MASK;
      pend_wdata_q <= req_wdata;
      pend_be_q    <= req_byteen;
    end
  end

  assign push = pend_q;
  assign pop  = log_valid & log_ready;

  // Log FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Log FIFO storage; the merge uses the old word read on the accept edge.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]   <= pend_pc_q;
      fifo_addr[wr_ptr_q] <= pend_addr_q;
      fifo_data[wr_ptr_q] <= merge_lanes(rdata_pn[0], pend_wdata_q, pend_be_q);
    end
  end

  // First-word-fall-through view of the log head.
  always_comb begin
    log_valid = (cnt_q != '0);
    log_pc    = fifo_pc[rd_ptr_q];
    log_addr  = fifo_addr[rd_ptr_q];
    log_data  = fifo_data[rd_ptr_q];
  end

endmodule

// File: tb/tb_dm_byteen_ram.sv
// Directed bench for dm_byteen_ram: ADDR_W=4, LANES=4, READ_LAT=3, LOG_DEPTH=4.
module tb_dm_byteen_ram;

  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_byteen = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        log_valid;
  logic        log_ready = 1'b1;
  logic [31:0] log_pc;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        clearing;

  dm_byteen_ram #(
    .ADDR_W(4), .LANES(4), .READ_LAT(RL), .BASE_ADDR(32'h0), .LOG_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_byteen(req_byteen), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .log_valid(log_valid), .log_ready(log_ready), .log_pc(log_pc),
    .log_addr(log_addr), .log_data(log_data), .clearing(clearing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [32:0] rsp_q[$];
  int          rsp_cyc_q[$];
  logic [95:0] log_q[$];

  // Capture responses and consumed log entries away from the active edge.
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_q.push_back({rsp_err, rsp_rdata});
      rsp_cyc_q.push_back(cyc);
    end
    if (log_valid && log_ready) log_q.push_back({log_pc, log_addr, log_data});
  end

  int n_tests = 0;
  int n_fail  = 0;
  int last_acc_cyc = 0;
  int last_rsp_cyc = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request until accepted or the budget runs out.
  task automatic issue(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] pc, input int budget, output bit acc);
    int n;
    n   = 0;
    acc = 1'b0;
    req_valid  = 1'b1;
    req_addr   = a;
    req_byteen = be;
    req_wdata  = wd;
    req_pc     = pc;
    while (!acc && n < budget) begin
      @(negedge clk);
      acc = req_ready;
      last_acc_cyc = cyc;
      tick();
      n++;
    end
    req_valid  = 1'b0;
    req_byteen = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    bit ok;
    issue(a, 4'b0000, 32'h0, 32'h0, 40, ok);
    check({tag, "_acc"}, ok, 1);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] wd, input logic [31:0] pc);
    bit ok;
    issue(a, be, wd, pc, 40, ok);
    check({tag, "_acc"}, ok, 1);
  endtask

  task automatic expect_rsp(input string tag, input logic e_err, input logic [31:0] e_data);
    int w;
    w = 0;
    while (rsp_q.size() == 0 && w < 20) begin
      tick();
      w++;
    end
    if (rsp_q.size() == 0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      last_rsp_cyc = rsp_cyc_q.pop_front();
      check(tag, rsp_q.pop_front(), {e_err, e_data});
    end
  endtask

  task automatic expect_log(input string tag, input logic [31:0] pc, input logic [31:0] a,
                            input logic [31:0] d);
    int w;
    w = 0;
    while (log_q.size() == 0 && w < 20) begin
      tick();
      w++;
    end
    if (log_q.size() == 0) check({tag, "_timeout"}, 0, 1);
    else                   check(tag, log_q.pop_front(), {pc, a, d});
  endtask

  task automatic wait_clear(input string tag, output int n, output int bad);
    n   = 0;
    bad = 0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (!clearing) break;
      n++;
      if (req_ready) bad++;
    end
    tick();
    check({tag, "_ready_while_clear"}, bad, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ncl, bad, t0, n_acc, pre;
    bit          ok;
    logic [5:0]  acc_mask;
    logic [31:0] d;

    // Reset state
    repeat (3) tick();
    check("rst_outs", {req_ready, rsp_valid, rsp_err, log_valid, clearing}, 5'b00001);
    check("rst_rdata", rsp_rdata, 0);

    // 1: clear sweep, then every word reads zero
    reset = 1'b1;
    wait_clear("t1", ncl, bad);
    check("t1_clear_cycles", ncl, 16);
    check("t1_run_ready", req_ready, 1);
    for (int i = 0; i < 16; i++) rd($sformatf("t1_rd%0d", i), 32'(i * 4));
    for (int i = 0; i < 16; i++) expect_rsp($sformatf("t1_rsp%0d", i), 1'b0, 32'h0);

    // 2: full-word write, log entry, read-back latency
    wr("t2_wr", 32'h10, 4'b1111, 32'h12345678, 32'h3000);
    expect_rsp("t2_wr_old", 1'b0, 32'h0);
    expect_log("t2_log", 32'h3000, 32'h10, 32'h12345678);
    rd("t2_rd", 32'h10);
    t0 = last_acc_cyc;
    expect_rsp("t2_rd_data", 1'b0, 32'h12345678);
    check("t2_latency", last_rsp_cyc - t0, RL);

    // 3: single-lane write then back-to-back read of the same word
    wr("t3_wr", 32'h13, 4'b0100, 32'hAABBCCDD, 32'h3004);
    t0 = last_acc_cyc;
    rd("t3_rd", 32'h10);
    check("t3_back_to_back", last_acc_cyc - t0, 1);
    expect_rsp("t3_wr_old", 1'b0, 32'h12345678);
    expect_rsp("t3_rd_data", 1'b0, 32'h12BB5678);
    expect_log("t3_log", 32'h3004, 32'h10, 32'h12BB5678);

    // 4: out-of-window read and write
    rd("t4_rd", 32'h40);
    wr("t4_wr", 32'h40, 4'b1111, 32'hFFFFFFFF, 32'h3008);
    expect_rsp("t4_rd_oor", 1'b1, 32'h0);
    expect_rsp("t4_wr_oor", 1'b1, 32'h0);
    repeat (4) tick();
    check("t4_no_log", log_q.size(), 0);
    rd("t4_rd0", 32'h0);
    rd("t4_rd10", 32'h10);
    expect_rsp("t4_word0", 1'b0, 32'h0);
    expect_rsp("t4_word4", 1'b0, 32'h12BB5678);

    // 5: log backpressure limits accepted writes to the FIFO depth
    log_ready = 1'b0;
    n_acc     = 0;
    acc_mask  = '0;
    for (int k = 0; k < 6; k++) begin
      d = 32'h11111111 * 32'(k + 1);
      issue(32'h20 + 32'(4 * k), 4'b1111, d, 32'h4000 + 32'(4 * k), 6, ok);
      acc_mask[k] = ok;
      if (ok) n_acc++;
    end
    check("t5_n_accepted", n_acc, 4);
    check("t5_accept_mask", acc_mask, 6'b001111);
    check("t5_ready_low", req_ready, 0);
    issue(32'h10, 4'b0000, 32'h0, 32'h0, 5, ok);
    check("t5_read_stalled", ok, 0);
    for (int k = 0; k < 4; k++) expect_rsp($sformatf("t5_wr_old%0d", k), 1'b0, 32'h0);
    check("t5_no_pop_yet", log_q.size(), 0);
    log_ready = 1'b1;
    repeat (8) tick();
    check("t5_popped", log_q.size(), 4);
    for (int k = 0; k < 4; k++)
      expect_log($sformatf("t5_log%0d", k), 32'h4000 + 32'(4 * k), 32'h20 + 32'(4 * k),
                 32'h11111111 * 32'(k + 1));
    wr("t5_wr4", 32'h30, 4'b1111, 32'h55555555, 32'h4010);
    wr("t5_wr5", 32'h34, 4'b1111, 32'h66666666, 32'h4014);
    rd("t5_rd", 32'h10);
    expect_rsp("t5_wr4_old", 1'b0, 32'h0);
    expect_rsp("t5_wr5_old", 1'b0, 32'h0);
    expect_rsp("t5_rd_data", 1'b0, 32'h12BB5678);
    expect_log("t5_log4", 32'h4010, 32'h30, 32'h55555555);
    expect_log("t5_log5", 32'h4014, 32'h34, 32'h66666666);

    // 6: reset with three responses in flight and a log entry pending
    log_ready = 1'b0;
    wr("t6_wr", 32'h14, 4'b1111, 32'hCAFEF00D, 32'h5000);
    rd("t6_rd0", 32'h10);
    rd("t6_rd1", 32'h14);
    check("t6_pre", {rsp_valid, log_valid}, 2'b11);
    pre = rsp_q.size();
    reset = 1'b0;
    #1;
    check("t6_rst_now", {rsp_valid, log_valid, clearing, req_ready}, 4'b0010);
    repeat (3) tick();
    reset     = 1'b1;
    log_ready = 1'b1;
    wait_clear("t6", ncl, bad);
    check("t6_clear_cycles", ncl, 16);
    repeat (4) tick();
    check("t6_no_stale_rsp", rsp_q.size(), pre);
    check("t6_no_stale_log", log_q.size(), 0);
    rd("t6_rd10", 32'h10);
    rd("t6_rd14", 32'h14);
    expect_rsp("t6_word4_zero", 1'b0, 32'h0);
    expect_rsp("t6_word5_zero", 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
